// File: rtl/imem_arbiter_pkg.sv
// Shared types and constants for the instruction-memory arbiter.
// Holds the arbitration state enum, memory geometry and address decode helpers.
package imem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } arb_state_e;

    localparam int unsigned MEM_DEPTH = 256;
    localparam int unsigned IDX_W     = 8;
    localparam logic [31:0] NOP_WORD  = 32'hE1A00000;

    // Only the low 1 KiB is backed by memory; bits [1:0] are a byte offset.
    function automatic logic addr_in_range(input logic [31:0] addr);
        return addr[31:IDX_W+2] == '0;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
        return addr[IDX_W+1:2];
    endfunction

endpackage

// File: rtl/imem_arbiter_if.sv
// Bundle of fetch, loader and memory-side signals around the arbiter.
// slave = arbiter side, master = fetch stage / boot loader / memory side.
interface imem_arbiter_if;
    import imem_arbiter_pkg::*;

    logic              fetch_req;
    logic [31:0]       fetch_addr;
    logic              fetch_gnt;
    logic              fetch_rvalid;
    logic [31:0]       fetch_rdata;
    logic              ld_req;
    logic [31:0]       ld_addr;
    logic [31:0]       ld_wdata;
    logic              ld_gnt;
    logic              ld_err;
    logic              mem_en;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  fetch_req, fetch_addr, ld_req, ld_addr, ld_wdata, mem_rdata,
        output fetch_gnt, fetch_rvalid, fetch_rdata, ld_gnt, ld_err,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output fetch_req, fetch_addr, ld_req, ld_addr, ld_wdata, mem_rdata,
        input  fetch_gnt, fetch_rvalid, fetch_rdata, ld_gnt, ld_err,
               mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/imem_starve_cnt.sv
// Counts consecutive loader wins over a pending fetch and flags when the
// fetch must be forced through on its next request.
module imem_starve_cnt #(
    parameter int unsigned LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic fetch_req,
    input  logic fetch_gnt,
    input  logic ld_gnt,
    output logic starve
);
    localparam int unsigned CNT_W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: default assignment first so every path drives cnt_d and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (!fetch_req || fetch_gnt) begin
            cnt_d = '0;
        end else if (ld_gnt) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign starve = (cnt_q >= CNT_W'(LIMIT));

endmodule

// File: rtl/imem_arbiter.sv
// Arbitrates a fetch stage and a boot loader onto one 256x32 synchronous memory.
// Loader port and starvation guard exist only when IMEM_LOADER_EN is defined.
module imem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter logic [31:0] NOP_WORD     = imem_arbiter_pkg::NOP_WORD
) (
    input  logic           clk,
    input  logic           rst,
    imem_arbiter_if.slave  bus
);
    import imem_arbiter_pkg::*;

    logic        ld_req;
    logic [31:0] ld_addr;
    logic [31:0] ld_wdata;
    logic        starve;
    logic        fetch_gnt;
    logic        ld_gnt;
    logic        fetch_ok;
    logic        ld_ok;

    arb_state_e  state_q, state_d;
    logic        rd_nop_q, rd_nop_d;
    logic        ld_err_q, ld_err_d;

`ifdef IMEM_LOADER_EN
    assign ld_req   = bus.ld_req;
    assign ld_addr  = bus.ld_addr;
    assign ld_wdata = bus.ld_wdata;
`else
    // Loader tied off; the counter below then never advances and folds away.
    logic unused_ld;
    assign unused_ld = ^{bus.ld_req, bus.ld_addr, bus.ld_wdata};
    assign ld_req    = 1'b0;
    assign ld_addr   = '0;
    assign ld_wdata  = '0;
`endif

    imem_starve_cnt #(
        .LIMIT     (STARVE_LIMIT)
    ) u_starve_cnt (
        .clk       (clk),
        .rst       (rst),
        .fetch_req (bus.fetch_req),
        .fetch_gnt (fetch_gnt),
        .ld_gnt    (ld_gnt),
        .starve    (starve)
    );

    always_comb begin
        fetch_gnt = !rst && bus.fetch_req && (!ld_req || starve);
        ld_gnt    = !rst && ld_req && !fetch_gnt;
        fetch_ok  = addr_in_range(bus.fetch_addr);
        ld_ok     = addr_in_range(ld_addr);

        if (fetch_gnt) begin
            state_d = ST_RD;
        end else if (ld_gnt) begin
            state_d = ST_WR;
        end else begin
            state_d = ST_IDLE;
        end
        rd_nop_d = fetch_gnt && !fetch_ok;
        ld_err_d = ld_gnt && !ld_ok;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rd_nop_q <= 1'b0;
            ld_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_nop_q <= rd_nop_d;
            ld_err_q <= ld_err_d;
        end
    end

    assign bus.fetch_gnt    = fetch_gnt;
    assign bus.ld_gnt       = ld_gnt;
    assign bus.mem_en       = (fetch_gnt && fetch_ok) || (ld_gnt && ld_ok);
    assign bus.mem_we       = ld_gnt && ld_ok;
    assign bus.mem_addr     = ld_gnt ? word_idx(ld_addr) : word_idx(bus.fetch_addr);
    assign bus.mem_wdata    = ld_wdata;

    // Registered flags are masked by rst so the first reset cycle is already quiet.
    assign bus.fetch_rvalid = !rst && (state_q == ST_RD);
    assign bus.fetch_rdata  = !bus.fetch_rvalid ? '0 :
                              rd_nop_q          ? NOP_WORD : bus.mem_rdata;
    assign bus.ld_err       = !rst && ld_err_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed, table-driven bench for imem_arbiter with a behavioural 256x32 memory.
// Expectations follow IMEM_LOADER_EN when the bench is built with it.
module tb_imem_arbiter;
    import imem_arbiter_pkg::*;

    typedef struct {
        logic        rst;
        logic        f_req;
        logic [31:0] f_addr;
        logic        l_req;
        logic [31:0] l_addr;
        logic [31:0] l_wdata;
        logic        e_fgnt;
        logic        e_lgnt;
        logic        e_en;
        logic        e_we;
        logic [7:0]  e_addr;
        logic [31:0] e_wdata;
        logic        e_rvalid;
        logic [31:0] e_rdata;
        logic        e_err;
    } vec_t;

    localparam logic [31:0] NOP = 32'hE1A00000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    imem_arbiter_if bus ();

    imem_arbiter #(
        .STARVE_LIMIT (4),
        .NOP_WORD     (NOP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Memory model: preloaded with 0xA0000000+index whenever rst is sampled.
    logic [31:0] mem [MEM_DEPTH];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= 32'hA000_0000 + i;
            bus.mem_rdata <= '0;
        end else if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= mem[bus.mem_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic r, input logic fq, input logic [31:0] fa,
        input logic lq, input logic [31:0] la, input logic [31:0] lw,
        input logic fg, input logic lg, input logic en, input logic we,
        input logic [7:0] ma, input logic [31:0] mw,
        input logic rv, input logic [31:0] rd, input logic er);
        vec_t v;
        v.rst = r;  v.f_req = fq; v.f_addr = fa;
        v.l_req = lq; v.l_addr = la; v.l_wdata = lw;
        v.e_fgnt = fg; v.e_lgnt = lg; v.e_en = en; v.e_we = we;
        v.e_addr = ma; v.e_wdata = mw;
        v.e_rvalid = rv; v.e_rdata = rd; v.e_err = er;
        return v;
    endfunction

    task automatic drive(input logic r, input logic fq, input logic [31:0] fa,
                         input logic lq, input logic [31:0] la, input logic [31:0] lw);
        rst            = r;
        bus.fetch_req  = fq;
        bus.fetch_addr = fa;
        bus.ld_req     = lq;
        bus.ld_addr    = la;
        bus.ld_wdata   = lw;
    endtask

    task automatic apply(input vec_t v, input string tag);
        drive(v.rst, v.f_req, v.f_addr, v.l_req, v.l_addr, v.l_wdata);
        @(negedge clk);
        check({tag, " fetch_gnt"},    32'(bus.fetch_gnt),    32'(v.e_fgnt));
        check({tag, " ld_gnt"},       32'(bus.ld_gnt),       32'(v.e_lgnt));
        check({tag, " mem_en"},       32'(bus.mem_en),       32'(v.e_en));
        check({tag, " mem_we"},       32'(bus.mem_we),       32'(v.e_we));
        check({tag, " fetch_rvalid"}, 32'(bus.fetch_rvalid), 32'(v.e_rvalid));
        check({tag, " ld_err"},       32'(bus.ld_err),       32'(v.e_err));
        if (v.e_rvalid || v.rst) check({tag, " fetch_rdata"}, bus.fetch_rdata, v.e_rdata);
        if (v.e_en) check({tag, " mem_addr"}, 32'(bus.mem_addr), 32'(v.e_addr));
        if (v.e_we) check({tag, " mem_wdata"}, bus.mem_wdata, v.e_wdata);
        @(posedge clk);
        #1;
    endtask

    task automatic grants(input logic fq, input logic lq, input logic ef, input logic el,
                          input string tag);
        drive(1'b0, fq, 32'h8, lq, 32'h48, 32'h55);
        @(negedge clk);
        check({tag, " fetch_gnt"}, 32'(bus.fetch_gnt), 32'(ef));
        check({tag, " ld_gnt"},    32'(bus.ld_gnt),    32'(el));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        drive(1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);

        // rst fq  faddr          lq  laddr   lwdata          fg lg en we addr   wdata  rv rdata           err
        vecs.push_back(mk(1, 1, 32'h0,        0, 32'h0, 32'h0,  0, 0, 0, 0, 8'd0,  32'h0, 0, 32'h0,        0));
        vecs.push_back(mk(1, 1, 32'h0,        0, 32'h0, 32'h0,  0, 0, 0, 0, 8'd0,  32'h0, 0, 32'h0,        0));
        vecs.push_back(mk(1, 1, 32'h0,        0, 32'h0, 32'h0,  0, 0, 0, 0, 8'd0,  32'h0, 0, 32'h0,        0));
        vecs.push_back(mk(0, 1, 32'h0,        0, 32'h0, 32'h0,  1, 0, 1, 0, 8'd0,  32'h0, 0, 32'h0,        0));
        vecs.push_back(mk(0, 1, 32'h4,        0, 32'h0, 32'h0,  1, 0, 1, 0, 8'd1,  32'h0, 1, 32'hA0000000, 0));
        vecs.push_back(mk(0, 1, 32'h8,        0, 32'h0, 32'h0,  1, 0, 1, 0, 8'd2,  32'h0, 1, 32'hA0000001, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0, 32'h0,  0, 0, 0, 0, 8'd0,  32'h0, 1, 32'hA0000002, 0));
        vecs.push_back(mk(0, 1, 32'h400,      0, 32'h0, 32'h0,  1, 0, 0, 0, 8'd0,  32'h0, 0, 32'h0,        0));
        vecs.push_back(mk(0, 1, 32'h3FF,      0, 32'h0, 32'h0,  1, 0, 1, 0, 8'd255,32'h0, 1, NOP,          0));
        vecs.push_back(mk(0, 1, 32'h80000010, 0, 32'h0, 32'h0,  1, 0, 0, 0, 8'd0,  32'h0, 1, 32'hA00000FF, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0, 32'h0,  0, 0, 0, 0, 8'd0,  32'h0, 1, NOP,          0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0, 32'h0,  0, 0, 0, 0, 8'd0,  32'h0, 0, 32'h0,        0));
        // Read in flight when rst rises must not surface afterwards.
        vecs.push_back(mk(0, 1, 32'h10,       0, 32'h0, 32'h0,  1, 0, 1, 0, 8'd4,  32'h0, 0, 32'h0,        0));
        vecs.push_back(mk(1, 0, 32'h0,        0, 32'h0, 32'h0,  0, 0, 0, 0, 8'd0,  32'h0, 0, 32'h0,        0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0, 32'h0,  0, 0, 0, 0, 8'd0,  32'h0, 0, 32'h0,        0));
`ifdef IMEM_LOADER_EN
        vecs.push_back(mk(0, 0, 32'h0,        1, 32'h40, 32'hE3A00014, 0, 1, 1, 1, 8'd16, 32'hE3A00014, 0, 32'h0, 0));
        vecs.push_back(mk(0, 1, 32'h40,       0, 32'h0, 32'h0,  1, 0, 1, 0, 8'd16, 32'h0, 0, 32'h0,        0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0, 32'h0,  0, 0, 0, 0, 8'd0,  32'h0, 1, 32'hE3A00014, 0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 32'h400, 32'hDEADBEEF, 0, 1, 0, 0, 8'd0, 32'h0, 0, 32'h0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0, 32'h0,  0, 0, 0, 0, 8'd0,  32'h0, 0, 32'h0,        1));
        vecs.push_back(mk(0, 1, 32'h0,        0, 32'h0, 32'h0,  1, 0, 1, 0, 8'd0,  32'h0, 0, 32'h0,        0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0, 32'h0,  0, 0, 0, 0, 8'd0,  32'h0, 1, 32'hA0000000, 0));
        vecs.push_back(mk(0, 1, 32'h8,        1, 32'h44, 32'h11111111, 0, 1, 1, 1, 8'd17, 32'h11111111, 0, 32'h0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0, 32'h0,  0, 0, 0, 0, 8'd0,  32'h0, 0, 32'h0,        0));
`else
        vecs.push_back(mk(0, 1, 32'h40,       1, 32'h44, 32'h12345678, 1, 0, 1, 0, 8'd16, 32'h0, 0, 32'h0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 32'h48, 32'h12345678, 0, 0, 0, 0, 8'd0,  32'h0, 1, 32'hA0000010, 0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 32'h400, 32'hDEADBEEF, 0, 0, 0, 0, 8'd0, 32'h0, 0, 32'h0,  0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0, 32'h0,  0, 0, 0, 0, 8'd0,  32'h0, 0, 32'h0,        0));
        vecs.push_back(mk(0, 1, 32'h44,       1, 32'h44, 32'hCAFEF00D, 1, 0, 1, 0, 8'd17, 32'h0, 0, 32'h0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0, 32'h0,  0, 0, 0, 0, 8'd0,  32'h0, 1, 32'hA0000011, 0));
`endif

        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

`ifdef IMEM_LOADER_EN
        // Continuous contention: four loader grants, then one forced fetch.
        for (int i = 0; i < 10; i++) begin
            grants(1'b1, 1'b1, (i % 5) == 4, (i % 5) != 4, $sformatf("starve%0d", i));
        end
        // An idle fetch cycle clears the count; the full four-grant run restarts.
        grants(1'b1, 1'b1, 1'b0, 1'b1, "clr0");
        grants(1'b1, 1'b1, 1'b0, 1'b1, "clr1");
        grants(1'b0, 1'b1, 1'b0, 1'b1, "clr2");
        for (int i = 0; i < 5; i++) begin
            grants(1'b1, 1'b1, i == 4, i != 4, $sformatf("clr_run%0d", i));
        end
`else
        for (int i = 0; i < 8; i++) begin
            grants(1'b1, 1'b1, 1'b1, 1'b0, $sformatf("noload%0d", i));
        end
`endif

        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
